usb_rx_ctrl: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 85 ++++++++
 rtl/usb_rx_if.sv | 40 ++++
 rtl/usb_rx_wdog.sv | 38 +++
 rtl/usb_rx_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types for the USB bulk RX control path: FSM states, error codes,
// decoder status encodings and the state-to-control decode.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SYNC       = 4'd1,
        ST_CHECK_SYNC = 4'd2,
        ST_PID        = 4'd3,
        ST_CHECK_PID  = 4'd4,
        ST_TOKEN      = 4'd5,
        ST_DATA       = 4'd6,
        ST_CHECK5     = 4'd7,
        ST_CHECK16    = 4'd8,
        ST_HSHAKE     = 4'd9,
        ST_ERROR      = 4'd10,
        ST_DONE       = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_SYNC      = 3'd1,
        ERR_PID       = 3'd2,
        ERR_CRC       = 3'd3,
        ERR_LENGTH    = 3'd4,
        ERR_OVERFLOW  = 3'd5,
        ERR_STATUS_TO = 3'd6,
        ERR_IDLE_TO   = 3'd7
    } err_e;

    localparam logic [1:0] SYNC_PENDING = 2'b00;
    localparam logic [1:0] SYNC_OK      = 2'b01;
    localparam logic [2:0] PID_PENDING  = 3'b000;
    localparam logic [2:0] PID_TOKEN    = 3'b001;
    localparam logic [2:0] PID_DATA     = 3'b010;
    localparam logic [2:0] PID_HSHAKE   = 3'b011;
    localparam logic [1:0] CRC_PENDING  = 2'b00;
    localparam logic [1:0] CRC_OK       = 2'b01;

    typedef struct packed {
        logic enable_timer;
        logic load_sync;
        logic check_sync;
        logic load_pid;
        logic check_pid;
        logic load_data;
        logic crc_check_5;
        logic crc_check_16;
        logic load_error;
        logic load_done;
        logic busy;
    } ctrl_t;

    // Two-bit sync/CRC status: any value with the upper bit set is a failure.
    function automatic logic status_bad(input logic [1:0] st);
        return st[1];
    endfunction

    function automatic logic is_check(input state_e st);
        return (st == ST_CHECK_SYNC) || (st == ST_CHECK_PID) ||
               (st == ST_CHECK5)     || (st == ST_CHECK16);
    endfunction

    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c      = '0;
        c.busy = (st != ST_IDLE);
        case (st)
            ST_SYNC:       begin c.enable_timer = 1'b1; c.load_sync  = 1'b1; end
            ST_CHECK_SYNC: begin c.enable_timer = 1'b1; c.check_sync = 1'b1; end
            ST_PID:        begin c.enable_timer = 1'b1; c.load_pid   = 1'b1; end
            ST_CHECK_PID:  begin c.enable_timer = 1'b1; c.check_pid  = 1'b1; end
            ST_TOKEN:      c.enable_timer = 1'b1;
            ST_DATA:       begin c.enable_timer = 1'b1; c.load_data  = 1'b1; end
            ST_CHECK5:     c.crc_check_5  = 1'b1;
            ST_CHECK16:    c.crc_check_16 = 1'b1;
            ST_HSHAKE:     c.enable_timer = 1'b1;
            ST_ERROR:      c.load_error   = 1'b1;
            ST_DONE:       c.load_done    = 1'b1;
            default:       c.busy         = c.busy;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/usb_rx_if.sv
// RX datapath <-> receive controller signal bundle. The controller uses the
// slave modport; the datapath/buffer side uses master.
interface usb_rx_if #(parameter int CNT_W = 7) ();
    logic             d_edge;
    logic             byte_complete;
    logic             eop_detected;
    logic [1:0]       sync_status;
    logic [2:0]       pid_status;
    logic [1:0]       crc_status;
    logic             buf_full;
    logic             enable_timer;
    logic             load_sync;
    logic             check_sync;
    logic             load_pid;
    logic             check_pid;
    logic             load_data;
    logic             crc_check_5;
    logic             crc_check_16;
    logic             load_error;
    logic             load_done;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] byte_count;
    logic             busy;

    modport master (
        output d_edge, byte_complete, eop_detected, sync_status, pid_status,
               crc_status, buf_full,
        input  enable_timer, load_sync, check_sync, load_pid, check_pid,
               load_data, crc_check_5, crc_check_16, load_error, load_done,
               err_code, byte_count, busy
    );

    modport slave (
        input  d_edge, byte_complete, eop_detected, sync_status, pid_status,
               crc_status, buf_full,
        output enable_timer, load_sync, check_sync, load_pid, check_pid,
               load_data, crc_check_5, crc_check_16, load_error, load_done,
               err_code, byte_count, busy
    );
endinterface

// File: rtl/usb_rx_wdog.sv
// Loadable down-counter: load sets LIMIT-1, run decrements toward zero and
// expired is high once LIMIT run cycles have elapsed since the load.
module usb_rx_wdog #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins over decrement; holds at zero once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LIMIT - 1);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/usb_rx_ctrl.sv
// USB bulk-endpoint RX control FSM with length, overflow and watchdog checks.
// Optional mid-packet bus-idle timeout: define USB_RX_IDLE_TIMEOUT_EN.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int CNT_W          = 7,
    parameter int STATUS_WAIT    = 16,
    parameter int IDLE_LIMIT     = 64
) (
    input logic    clk,
    input logic    rst,
    usb_rx_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_DATA_BYTES + 2);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_e           state_q, state_d, nxt_s;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    err_e             err_code_q, err_code_d, err_sel_s;
    ctrl_t            ctrl_q, ctrl_d;
    logic             err_hit_s;
    logic [CNT_W-1:0] cnt_inc_s, eff_cnt_s;
    logic             stat_load_s, stat_exp_s, stat_wdog_exp_s;
    logic             idle_to_s;

    assign cnt_inc_s = (&byte_count_q) ? byte_count_q : byte_count_q + CNT_W'(1);
    assign eff_cnt_s = bus.byte_complete ? cnt_inc_s : byte_count_q;

    assign stat_load_s = is_check(state_d) && (state_d != state_q);
    assign stat_exp_s  = stat_wdog_exp_s && is_check(state_q);

    usb_rx_wdog #(.LIMIT(STATUS_WAIT)) u_stat_wdog (
        .clk     (clk),
        .rst     (rst),
        .load    (stat_load_s),
        .run     (is_check(state_q)),
        .expired (stat_wdog_exp_s)
    );

`ifdef USB_RX_IDLE_TIMEOUT_EN
    logic idle_run_s, idle_exp_s;

    assign idle_run_s = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                        (state_q == ST_TOKEN) || (state_q == ST_DATA) ||
                        (state_q == ST_HSHAKE);
    assign idle_to_s  = idle_run_s && idle_exp_s && !bus.d_edge;

    usb_rx_wdog #(.LIMIT(IDLE_LIMIT)) u_idle_wdog (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.d_edge),
        .run     (idle_run_s),
        .expired (idle_exp_s)
    );
`else
    // Feature absent: tied low (the compare is constant-false for any legal limit).
    assign idle_to_s = (IDLE_LIMIT < 0);
`endif

    // Next-state, byte counter and error selection.
    always_comb begin
        nxt_s        = state_q;
        byte_count_d = byte_count_q;
        err_hit_s    = 1'b0;
        err_sel_s    = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (bus.d_edge) begin
                    nxt_s        = ST_SYNC;
                    byte_count_d = '0;
                end else begin
                    nxt_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (bus.byte_complete)     nxt_s = ST_CHECK_SYNC;
                else if (bus.eop_detected) begin err_hit_s = 1'b1; err_sel_s = ERR_SYNC; end
                else if (idle_to_s)        begin err_hit_s = 1'b1; err_sel_s = ERR_IDLE_TO; end
                else                       nxt_s = ST_SYNC;
            end
            ST_CHECK_SYNC: begin
                if (bus.sync_status == SYNC_OK)      nxt_s = ST_PID;
                else if (status_bad(bus.sync_status)) begin err_hit_s = 1'b1; err_sel_s = ERR_SYNC; end
                else if (stat_exp_s)                 begin err_hit_s = 1'b1; err_sel_s = ERR_STATUS_TO; end
                else                                 nxt_s = ST_CHECK_SYNC;
            end
            ST_PID: begin
                if (bus.byte_complete)     nxt_s = ST_CHECK_PID;
                else if (bus.eop_detected) begin err_hit_s = 1'b1; err_sel_s = ERR_PID; end
                else if (idle_to_s)        begin err_hit_s = 1'b1; err_sel_s = ERR_IDLE_TO; end
                else                       nxt_s = ST_PID;
            end
            ST_CHECK_PID: begin
                case (bus.pid_status)
                    PID_TOKEN:  nxt_s = ST_TOKEN;
                    PID_DATA:   nxt_s = ST_DATA;
                    PID_HSHAKE: nxt_s = ST_HSHAKE;
                    PID_PENDING: begin
                        if (stat_exp_s) begin err_hit_s = 1'b1; err_sel_s = ERR_STATUS_TO; end
                        else            nxt_s = ST_CHECK_PID;
                    end
                    default: begin err_hit_s = 1'b1; err_sel_s = ERR_PID; end
                endcase
            end
            ST_TOKEN: begin
                byte_count_d = eff_cnt_s;
                if (bus.eop_detected) begin
                    if (eff_cnt_s == TWO) nxt_s = ST_CHECK5;
                    else                  begin err_hit_s = 1'b1; err_sel_s = ERR_LENGTH; end
                end else if (idle_to_s) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_IDLE_TO;
                end else begin
                    nxt_s = ST_TOKEN;
                end
            end
            ST_DATA: begin
                // A byte arriving with EOP is counted before the length check.
                byte_count_d = eff_cnt_s;
                if (bus.byte_complete && bus.buf_full) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_OVERFLOW;
                end else if (eff_cnt_s > MAX_LEN) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_LENGTH;
                end else if (bus.eop_detected) begin
                    if (eff_cnt_s >= TWO) nxt_s = ST_CHECK16;
                    else                  begin err_hit_s = 1'b1; err_sel_s = ERR_LENGTH; end
                end else if (idle_to_s) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_IDLE_TO;
                end else begin
                    nxt_s = ST_DATA;
                end
            end
            ST_CHECK5, ST_CHECK16: begin
                if (bus.crc_status == CRC_OK)        nxt_s = ST_DONE;
                else if (status_bad(bus.crc_status)) begin err_hit_s = 1'b1; err_sel_s = ERR_CRC; end
                else if (stat_exp_s)                 begin err_hit_s = 1'b1; err_sel_s = ERR_STATUS_TO; end
                else                                 nxt_s = state_q;
            end
            ST_HSHAKE: begin
                if (bus.byte_complete) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_LENGTH;
                end else if (bus.eop_detected) begin
                    if (byte_count_q == '0) nxt_s = ST_DONE;
                    else                    begin err_hit_s = 1'b1; err_sel_s = ERR_LENGTH; end
                end else if (idle_to_s) begin
                    err_hit_s = 1'b1; err_sel_s = ERR_IDLE_TO;
                end else begin
                    nxt_s = ST_HSHAKE;
                end
            end
            ST_ERROR: nxt_s = ST_DONE;
            ST_DONE:  nxt_s = ST_IDLE;
            default:  nxt_s = ST_IDLE;
        endcase

        state_d    = err_hit_s ? ST_ERROR : nxt_s;
        err_code_d = err_hit_s ? err_sel_s :
                     ((state_q == ST_IDLE) && bus.d_edge) ? ERR_NONE : err_code_q;
        ctrl_d     = decode_ctrl(state_d);
    end

    // State, counters and Moore outputs; outputs are the decode of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_count_q <= '0;
            err_code_q   <= ERR_NONE;
            ctrl_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            err_code_q   <= err_code_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign bus.enable_timer = ctrl_q.enable_timer;
    assign bus.load_sync    = ctrl_q.load_sync;
    assign bus.check_sync   = ctrl_q.check_sync;
    assign bus.load_pid     = ctrl_q.load_pid;
    assign bus.check_pid    = ctrl_q.check_pid;
    assign bus.load_data    = ctrl_q.load_data;
    assign bus.crc_check_5  = ctrl_q.crc_check_5;
    assign bus.crc_check_16 = ctrl_q.crc_check_16;
    assign bus.load_error   = ctrl_q.load_error;
    assign bus.load_done    = ctrl_q.load_done;
    assign bus.busy         = ctrl_q.busy;
    assign bus.err_code     = err_code_q;
    assign bus.byte_count   = byte_count_q;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Scoreboard bench for usb_rx_ctrl: each packet pushes its expected outcome,
// the monitor pops and compares on every load_done pulse.
module tb_usb_rx_ctrl;
    localparam int CNT_W       = 7;
    localparam int STATUS_WAIT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_rx_if #(.CNT_W(CNT_W)) bus ();

    usb_rx_ctrl #(
        .MAX_DATA_BYTES (64),
        .CNT_W          (CNT_W),
        .STATUS_WAIT    (STATUS_WAIT),
        .IDLE_LIMIT     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // prev: control seen the cycle before DONE (0 error, 1 crc16, 2 crc5, 3 hshake)
    typedef struct {
        logic [2:0]       err;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       prev;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0, checks = 0;
    int done_cnt = 0, err_pulses = 0, start_done = 0;
    int c16_run = 0, c16_last = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int err, input int cnt, input int prev);
        exp_t e;
        e.err = 3'(err); e.cnt = CNT_W'(cnt); e.prev = 3'(prev);
        sb_q.push_back(e);
        start_done = done_cnt;
    endtask

    task automatic step(input logic de, input logic bc, input logic eop);
        bus.d_edge = de; bus.byte_complete = bc; bus.eop_detected = eop;
        @(negedge clk);
        #1;
        bus.d_edge = 1'b0; bus.byte_complete = 1'b0; bus.eop_detected = 1'b0;
    endtask

    task automatic pkt_head(input logic [2:0] pid);
        bus.pid_status = pid;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic bytes(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt == start_done && n < max) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk_val("done_seen", 32'(done_cnt != start_done), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_val("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    // Monitor: counts pulses, tracks CHECK16 dwell and scores each packet end.
    initial begin
        logic p_le, p_c16, p_c5, p_et;
        logic [2:0] pcode;
        exp_t e;
        p_le = 1'b0; p_c16 = 1'b0; p_c5 = 1'b0; p_et = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (bus.load_error) err_pulses++;
                if (bus.crc_check_16) c16_run++;
                else if (c16_run != 0) begin c16_last = c16_run; c16_run = 0; end
                if (bus.load_done) begin
                    done_cnt++;
                    pcode = p_le ? 3'd0 : p_c16 ? 3'd1 : p_c5 ? 3'd2 : p_et ? 3'd3 : 3'd7;
                    if (sb_q.size() == 0) begin
                        chk_val("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk_val("err_code", 32'(bus.err_code), 32'(e.err));
                        chk_val("byte_count", 32'(bus.byte_count), 32'(e.cnt));
                        chk_val("pre_done_state", 32'(pcode), 32'(e.prev));
                    end
                end
                p_le = bus.load_error; p_c16 = bus.crc_check_16;
                p_c5 = bus.crc_check_5; p_et = bus.enable_timer;
            end else begin
                p_le = 1'b0; p_c16 = 1'b0; p_c5 = 1'b0; p_et = 1'b0; c16_run = 0;
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {11'd0, bus.enable_timer, bus.load_sync, bus.check_sync, bus.load_pid,
                bus.check_pid, bus.load_data, bus.crc_check_5, bus.crc_check_16,
                bus.load_error, bus.load_done, bus.busy, bus.err_code, bus.byte_count};
    endfunction

    initial begin
        int ep;
        rst = 1'b1;
        bus.d_edge = 1'b0; bus.byte_complete = 1'b0; bus.eop_detected = 1'b0;
        bus.sync_status = 2'b01; bus.pid_status = 3'b000;
        bus.crc_status = 2'b00; bus.buf_full = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_val("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;

        // Good DATA0: 4 payload + 2 CRC.
        push_exp(0, 6, 1);
        pkt_head(3'b010);
        chk_val("in_data", 32'(bus.load_data), 32'd1);
        bytes(6);
        bus.crc_status = 2'b01;
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);
        chk_val("good_c16_cycles", 32'(c16_last), 32'd1);
        chk_val("hold_count", 32'(bus.byte_count), 32'd6);

        // Token with a third byte.
        ep = err_pulses;
        push_exp(4, 3, 0);
        pkt_head(3'b001);
        bytes(3);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);
        chk_val("one_error_pulse", 32'(err_pulses - ep), 32'd1);
        chk_val("hold_err", 32'(bus.err_code), 32'd4);

        // Token with the second byte coincident with EOP.
        push_exp(0, 2, 2);
        pkt_head(3'b001);
        bytes(1);
        step(1'b0, 1'b1, 1'b1);
        wait_done(10);

        // Overflow on the 3rd DATA byte.
        push_exp(5, 3, 0);
        pkt_head(3'b010);
        bytes(2);
        bus.buf_full = 1'b1;
        bytes(1);
        bus.buf_full = 1'b0;
        wait_done(10);

        // CRC stuck pending: status watchdog.
        bus.crc_status = 2'b00;
        push_exp(6, 2, 0);
        pkt_head(3'b010);
        bytes(2);
        step(1'b0, 1'b0, 1'b1);
        wait_done(40);
        chk_val("status_wait_cycles", 32'(c16_last), 32'(STATUS_WAIT));

        // Bad CRC.
        bus.crc_status = 2'b10;
        push_exp(3, 2, 0);
        pkt_head(3'b010);
        bytes(2);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);
        bus.crc_status = 2'b01;

        // Bad PID.
        push_exp(2, 0, 0);
        pkt_head(3'b101);
        wait_done(10);

        // ACK handshake.
        push_exp(0, 0, 3);
        pkt_head(3'b011);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);

        // DATA too short.
        push_exp(4, 1, 0);
        pkt_head(3'b010);
        bytes(1);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);

        // Bad SYNC.
        bus.sync_status = 2'b10;
        push_exp(1, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wait_done(10);
        bus.sync_status = 2'b01;

        // Longest legal DATA, then one byte too many.
        push_exp(0, 66, 1);
        pkt_head(3'b010);
        bytes(66);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);
        push_exp(4, 67, 0);
        pkt_head(3'b010);
        bytes(67);
        wait_done(10);

        // byte_complete during CHECK_PID is ignored.
        push_exp(0, 2, 1);
        bus.pid_status = 3'b000;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_val("stay_check_pid", 32'(bus.check_pid), 32'd1);
        bus.pid_status = 3'b010;
        step(1'b0, 1'b0, 1'b0);
        bytes(2);
        step(1'b0, 1'b0, 1'b1);
        wait_done(10);

        // Reset in the middle of DATA.
        ep = err_pulses;
        start_done = done_cnt;
        pkt_head(3'b010);
        bytes(2);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk_val("rst_mid_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_val("rst_no_pulses", 32'((err_pulses - ep) + (done_cnt - start_done)), 32'd0);

`ifdef USB_RX_IDLE_TIMEOUT_EN
        // Bus idle in PID.
        push_exp(7, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        wait_done(100);
`endif

        chk_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
